// File: rtl/ls_queue_pkg.sv
// ls_queue_pkg: shared op/size encodings, defaults, FSM states and decode helpers for the load/store queue
// Ports: none (package)
package ls_queue_pkg;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_ROB_W   = 4;
    localparam int DEF_NUM_CDB = 2;
    localparam int OP_W        = 3;

    typedef enum logic [OP_W-1:0] {
        LB_INST, LH_INST, LW_INST, LBU_INST, LHU_INST, SB_INST, SH_INST, SW_INST
    } op_type_t;

    typedef logic [DEF_ROB_W-1:0] rob_id_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    function automatic logic op_store(input op_type_t op);
        return op inside {SB_INST, SH_INST, SW_INST};
    endfunction

    function automatic logic op_signed(input op_type_t op);
        return op inside {LB_INST, LH_INST};
    endfunction

    function automatic logic [1:0] op_size(input op_type_t op);
        return (op inside {LB_INST, LBU_INST, SB_INST}) ? SZ_BYTE :
               (op inside {LH_INST, LHU_INST, SH_INST}) ? SZ_HALF : SZ_WORD;
    endfunction
endpackage

// File: rtl/ls_queue_if.sv
// ls_queue_if: issue, result-bus snoop, commit/flush, memory and load-result signals of the load/store queue
// Ports: master drives issue_*, cdb_*, commit_dest, flush, mem_ready, mem_rdata;
//        slave (the queue) drives full, mem_valid/we/size/addr/wdata, lsb_dest, lsb_value
interface ls_queue_if import ls_queue_pkg::*; #(
    parameter int XLEN    = DEF_XLEN,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int NUM_CDB = DEF_NUM_CDB
);
    logic [ROB_W-1:0]              issue_dest;
    op_type_t                      issue_op;
    logic [ROB_W-1:0]              issue_qj;
    logic [ROB_W-1:0]              issue_qk;
    logic [XLEN-1:0]               issue_vj;
    logic [XLEN-1:0]               issue_vk;
    logic [XLEN-1:0]               issue_imm;
    logic                          full;
    logic [NUM_CDB-1:0][ROB_W-1:0] cdb_dest;
    logic [NUM_CDB-1:0][XLEN-1:0]  cdb_value;
    logic [ROB_W-1:0]              commit_dest;
    logic                          flush;
    logic                          mem_valid;
    logic                          mem_we;
    logic [1:0]                    mem_size;
    logic [XLEN-1:0]               mem_addr;
    logic [XLEN-1:0]               mem_wdata;
    logic                          mem_ready;
    logic [XLEN-1:0]               mem_rdata;
    logic [ROB_W-1:0]              lsb_dest;
    logic [XLEN-1:0]               lsb_value;

    modport master (
        output issue_dest, issue_op, issue_qj, issue_qk, issue_vj, issue_vk, issue_imm,
               cdb_dest, cdb_value, commit_dest, flush, mem_ready, mem_rdata,
        input  full, mem_valid, mem_we, mem_size, mem_addr, mem_wdata, lsb_dest, lsb_value
    );

    modport slave (
        input  issue_dest, issue_op, issue_qj, issue_qk, issue_vj, issue_vk, issue_imm,
               cdb_dest, cdb_value, commit_dest, flush, mem_ready, mem_rdata,
        output full, mem_valid, mem_we, mem_size, mem_addr, mem_wdata, lsb_dest, lsb_value
    );
endinterface

// File: rtl/ls_queue_sign_ext.sv
// ls_queue_sign_ext: sign- or zero-extends the low byte/half of a loaded word
// Ports: i_data raw memory data, i_size access size, i_signed extend with sign, o_data extended result
module ls_queue_sign_ext import ls_queue_pkg::*; #(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    output logic [XLEN-1:0] o_data
);
    assign o_data = (i_size == SZ_BYTE) ? {{(XLEN-8){i_signed & i_data[7]}}, i_data[7:0]} :
                    (i_size == SZ_HALF) ? {{(XLEN-16){i_signed & i_data[15]}}, i_data[15:0]} : i_data;
endmodule

// File: rtl/ls_queue.sv
// ls_queue: circular program-ordered load/store queue executing one memory transaction at a time from the head
// Ports: i_clk clock, i_rst_n async active-low reset, i_rdy global stall (low freezes state),
//        io_bus issue/snoop/commit/flush inputs, memory request/response, load result broadcast
module ls_queue import ls_queue_pkg::*; #(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int XLEN    = DEF_XLEN,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int NUM_CDB = DEF_NUM_CDB
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_rdy,
    ls_queue_if.slave io_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    op_type_t         r_op   [DEPTH];
    logic [ROB_W-1:0] r_qj   [DEPTH];
    logic [ROB_W-1:0] r_qk   [DEPTH];
    logic [ROB_W-1:0] r_dest [DEPTH];
    logic [XLEN-1:0]  r_vj   [DEPTH];
    logic [XLEN-1:0]  r_vk   [DEPTH];
    logic [XLEN-1:0]  r_imm  [DEPTH];
    logic [DEPTH-1:0] r_com;
    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    state_t           r_state, w_state_nx;
    logic             r_we, r_sgn, r_kill;
    logic [1:0]       r_size;
    logic [XLEN-1:0]  r_addr, r_wdata, r_ld_raw;
    logic [ROB_W-1:0] r_lsb_dest;

    logic [NUM_CDB-1:0][ROB_W-1:0] w_cdb_dest;
    logic [NUM_CDB-1:0][XLEN-1:0]  w_cdb_value;
    logic [DEPTH-1:0] w_busy;
    logic [PW-1:0]    w_off;
    logic [CW-1:0]    w_ccnt, w_keep;
    logic [XLEN-1:0]  w_lsb_value;
    logic w_full, w_issue, w_hstore, w_elig, w_start, w_pop, w_inflight_unc;

    assign w_cdb_dest  = io_bus.cdb_dest;
    assign w_cdb_value = io_bus.cdb_value;

    // Returns {tag, value}; buses are scanned high to low so the lowest matching index wins.
    function automatic logic [ROB_W+XLEN-1:0] snoop(input logic [ROB_W-1:0] q, input logic [XLEN-1:0] v);
        logic [ROB_W+XLEN-1:0] res;
        res = {q, v};
        for (int c = NUM_CDB - 1; c >= 0; c--)
            if (q != '0 && w_cdb_dest[c] == q) res = {{ROB_W{1'b0}}, w_cdb_value[c]};
        return res;
    endfunction

    // Busy mask from head/count; committed entries are a prefix, so a popcount gives the survivor count.
    always_comb begin
        w_busy = '0;
        w_ccnt = '0;
        w_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off     = PW'(i) - r_head;
            w_busy[i] = CW'(w_off) < r_count;
            w_ccnt    = w_ccnt + CW'(w_busy[i] & r_com[i]);
        end
    end

    // An uncommitted load already on the bus must stay queued until its handshake completes.
    assign w_inflight_unc = r_state == S_WAIT_MEM && !r_com[r_head];
    assign w_keep   = w_ccnt + CW'(w_inflight_unc);
    assign w_full   = r_count == CW'(DEPTH);
    assign w_issue  = io_bus.issue_dest != '0 && !w_full && !io_bus.flush;
    assign w_hstore = op_store(r_op[r_head]);
    assign w_elig   = r_count != '0 && r_qj[r_head] == '0 &&
                      (!w_hstore || (r_qk[r_head] == '0 && r_com[r_head])) &&
                      (!io_bus.flush || r_com[r_head]);

    always_comb begin
        w_start    = r_state == S_IDLE && w_elig;
        w_pop      = r_state == S_WAIT_MEM && io_bus.mem_ready;
        w_state_nx = w_start ? S_WAIT_MEM : w_pop ? S_IDLE : r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else if (i_rdy) r_state <= w_state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                {r_qj[i], r_vj[i]} <= snoop(r_qj[i], r_vj[i]);
                {r_qk[i], r_vk[i]} <= snoop(r_qk[i], r_vk[i]);
            end
            if (w_issue) begin
                r_op[r_tail]   <= io_bus.issue_op;
                r_dest[r_tail] <= io_bus.issue_dest;
                r_imm[r_tail]  <= io_bus.issue_imm;
                {r_qj[r_tail], r_vj[r_tail]} <= snoop(io_bus.issue_qj, io_bus.issue_vj);
                {r_qk[r_tail], r_vk[r_tail]} <= snoop(io_bus.issue_qk, io_bus.issue_vk);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_com <= '0;
        else if (i_rdy) begin
            for (int i = 0; i < DEPTH; i++)
                if (!io_bus.flush && w_busy[i] && io_bus.commit_dest != '0 && r_dest[i] == io_bus.commit_dest)
                    r_com[i] <= 1'b1;
            if (w_issue) r_com[r_tail] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_sgn      <= 1'b0;
            r_kill     <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ld_raw   <= '0;
            r_lsb_dest <= '0;
        end else if (i_rdy) begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= io_bus.flush ? r_head + PW'(w_keep) : r_tail + PW'(w_issue);
            r_count <= io_bus.flush ? w_keep - CW'(w_pop) : r_count + CW'(w_issue) - CW'(w_pop);
            if (w_start) begin
                r_addr  <= r_vj[r_head] + r_imm[r_head];
                r_we    <= w_hstore;
                r_size  <= op_size(r_op[r_head]);
                r_sgn   <= op_signed(r_op[r_head]);
                r_wdata <= r_vk[r_head];
            end
            if (w_pop && !r_we) r_ld_raw <= io_bus.mem_rdata;
            // A flushed load still completes its handshake but its result is never broadcast.
            r_lsb_dest <= (w_pop && !r_we && !r_kill && !io_bus.flush) ? r_dest[r_head] : '0;
            r_kill     <= w_pop ? 1'b0 : (io_bus.flush && w_inflight_unc) ? 1'b1 : r_kill;
        end
    end

    ls_queue_sign_ext #(.XLEN(XLEN)) u_sign_ext (
        .i_data   (r_ld_raw),
        .i_size   (r_size),
        .i_signed (r_sgn),
        .o_data   (w_lsb_value)
    );

    assign io_bus.full      = w_full;
    assign io_bus.mem_valid = r_state == S_WAIT_MEM;
    assign io_bus.mem_we    = r_we;
    assign io_bus.mem_size  = r_size;
    assign io_bus.mem_addr  = r_addr;
    assign io_bus.mem_wdata = r_wdata;
    assign io_bus.lsb_dest  = r_lsb_dest;
    assign io_bus.lsb_value = w_lsb_value;
endmodule

// File: doc/ls_queue.md
# ls_queue

Parametrised successor of the load/store buffer: a circular, program-ordered load/store queue between the issuer, the common data buses and the memory controller. Entries wait for operands by ROB tag, execute strictly from the head, and drive one memory transaction at a time. Loads broadcast their results on the LSB bus. Stores write memory only after ROB commit, and committed stores survive a ROB flush.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥2.
- `XLEN`, 32: data/address width.
- `ROB_W`, 4: ROB tag width; tag 0 means "none/ready".
- `NUM_CDB`, 2: snooped result buses.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: low freezes all state; outputs hold.
- `issue_dest` in ROB_W: nonzero means issue this cycle.
- `issue_op` in OP_W: one of LB/LH/LW/LBU/LHU/SB/SH/SW.
- `issue_qj`, `issue_qk` in ROB_W: base/store-data producer tags.
- `issue_vj`, `issue_vk` in XLEN: base/store-data values.
- `issue_imm` in XLEN: sign-extended offset.
- `full` out 1: count == DEPTH.
- `cdb_dest` in NUM_CDB×ROB_W: packed bus tags; 0 means idle.
- `cdb_value` in NUM_CDB×XLEN: packed bus values.
- `commit_dest` in ROB_W: nonzero means the ROB commits the store with this tag.
- `flush` in 1: ROB misprediction reset.
- `mem_valid` out 1, `mem_we` out 1, `mem_size` out 2 (0 byte, 1 half, 2 word), `mem_addr` out XLEN, `mem_wdata` out XLEN.
- `mem_ready` in 1, `mem_rdata` in XLEN: the low bytes hold the data.
- `lsb_dest` out ROB_W, `lsb_value` out XLEN: load result, valid for one cycle when `lsb_dest` ≠ 0.

## Operation
- Storage: per-entry op, qj, qk, vj, vk, imm, dest, committed bit. Pointers `head` and `tail` (log2 DEPTH, wrap modulo DEPTH) plus `count` (log2(DEPTH+1) bits).
- Issue: when `issue_dest` ≠ 0 and not full, write the entry at `tail`, then advance `tail` and increment `count`. Issuing while full is a protocol error; the queue ignores it.
- Snoop: every entry with qj or qk equal to a nonzero `cdb_dest[i]` captures the matching value and clears its tag. An entry being issued this cycle also snoops. If several buses match, the lowest index wins.
- Commit: the entry whose dest equals `commit_dest` sets its committed bit. Committed entries always form a prefix from the head.
- Execute, FSM `IDLE` → `WAIT_MEM` → `IDLE`:
  - IDLE: the head entry is eligible when it is busy, qj = 0, and additionally, for stores, qk = 0 and committed.
  - On an eligible head: `mem_addr` = vj + imm (mod 2^XLEN), `mem_we` = store, `mem_size` from op, `mem_wdata` = vk, `mem_valid` = 1, then go to WAIT_MEM.
  - WAIT_MEM: request outputs are held stable until `mem_ready`.
  - On `mem_ready`: drop `mem_valid`, pop the head and return to IDLE.
  - For a load, drive `lsb_dest` = dest and `lsb_value` = `mem_rdata` sign- or zero-extended per op.
- Flush:
  - Discard every uncommitted entry; `tail` = head + committed count.
  - If a load is in WAIT_MEM, finish its handshake, discard its result (`lsb_dest` stays 0) and pop it.
  - An in-flight committed store completes normally.
  - A flush that coincides with issue, snoop or commit takes priority over those events.
- Simultaneous issue and pop: `count` is unchanged. `full` uses the registered `count`, so a full queue accepts no issue in its pop cycle.

## Timing
- Reset: all outputs 0, `count`/`head`/`tail` 0, FSM IDLE, all committed bits 0.
- Issue → entry eligible at the next edge. Eligible head in IDLE → `mem_valid` high after 1 edge.
- `mem_ready` sampled high at edge N → `lsb_dest`/`lsb_value` valid in cycle N+1 only. The next request can start at edge N+1 at the earliest.
- Snooped value → the entry can go eligible the cycle after capture.
- `rst` low mid-transaction: immediate return to the reset state; the pending memory request is abandoned.

## Structure
- Shared package/config header:
  - op encodings (`LB_INST`…`SW_INST`), `OP_TYPE`
  - `RO_BUFFER_ID_TYPE` and the size encodings
  - the DEPTH/XLEN defaults
  - FSM state constants
- Sub-module: the existing `sign_ext` for load extension, fed combinationally from the registered raw data and flags.

## Test plan
- Issue LW, dest 3, vj 0x100, imm 4, qj 0; `mem_ready` after 2 cycles with rdata 0xDEADBEEF → `mem_addr` 0x104, `mem_size` 2; `lsb_dest` 3 and `lsb_value` 0xDEADBEEF for one cycle.
- Issue LB, qj 5; `cdb_dest[1]` = 5 with value 0x200; rdata 0x80 → request at 0x200; `lsb_value` 0xFFFFFF80. Same sequence with LBU → `lsb_value` 0x00000080.
- Issue SW, dest 7, ready operands; hold with no commit for 10 cycles → `mem_valid` stays 0. Assert `commit_dest` 7 → next cycle `mem_we` 1, `mem_wdata` = vk.
- Fill 16 entries → `full` = 1. A 17th issue is ignored; wrap-around after 20 issue/retire pairs preserves program order.
- Commit 2 stores, add 3 uncommitted loads, pulse `flush` → `count` 2; both stores reach memory; no `lsb_dest` broadcast.
- Drop `rst` while in WAIT_MEM → `mem_valid` 0 and `count` 0 immediately, without waiting for a clock edge.
